// File: rtl/uart_tx_mmio_if.sv
// CPU-side MMIO bus for the UART transmitter: word address, write data/strobe,
// read data and the two address-decode qualifiers.
interface uart_tx_mmio_if;
  logic [29:0] address;
  logic [31:0] memory_out;
  logic        write_enable;
  logic [31:0] memory_in;
  logic        read_capable;
  logic        write_capable;

  modport master (
    output address, memory_out, write_enable,
    input  memory_in, read_capable, write_capable
  );

  modport slave (
    input  address, memory_out, write_enable,
    output memory_in, read_capable, write_capable
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TXDATA at BASE pushes into a small FIFO,
// STATUS at BASE+1. Define UART_TX_PARITY_EN to add an even-parity bit per frame.
module uart_tx_mmio #(
  parameter logic [29:0] BASE         = 30'h3FFFFFC0,
  parameter int          CLKS_PER_BIT = 4,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_mmio_if.slave  bus,
  output logic           tx
);
  localparam int          LW        = $clog2(FIFO_DEPTH);
  localparam logic [29:0] STAT_ADDR = BASE + 30'd1;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [LW:0] FULL_LVL  = FIFO_DEPTH[LW:0];
  localparam logic [LW:0] PTR_ONE   = 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [LW:0] wr_ptr, rd_ptr, level;
  logic        full, empty, overflow, busy;
  logic        wr_data_hit, wr_stat_hit, push, pop;
  logic [15:0] baud_cnt;
  logic        baud_done;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        tx_nxt;
  logic [31:0] status;
  logic        unused_wdata;
`ifdef UART_TX_PARITY_EN
  logic        par;
`endif

  assign unused_wdata = ^bus.memory_out[31:8];

  // Pointers carry one extra bit so full and empty stay distinct.
  assign level     = wr_ptr - rd_ptr;
  assign full      = (level == FULL_LVL);
  assign empty     = (level == '0);
  assign baud_done = (baud_cnt == BAUD_LAST);
  assign busy      = (state != IDLE);

  assign wr_data_hit = bus.write_enable && (bus.address == BASE);
  assign wr_stat_hit = bus.write_enable && (bus.address == STAT_ADDR);
  // A pop on the same edge frees a slot, so a write to a full FIFO still lands.
  assign push        = wr_data_hit && (!full || pop);

  assign status = 32'({overflow, busy, full, empty, level[LW-1:0]});

  always_comb begin
    bus.read_capable  = 1'b0;
    bus.write_capable = 1'b0;
    bus.memory_in     = '0;
    if (bus.address == BASE) begin
      bus.read_capable  = 1'b1;
      bus.write_capable = 1'b1;
    end else if (bus.address == STAT_ADDR) begin
      bus.read_capable  = 1'b1;
      bus.memory_in     = status;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[LW-1:0]] <= bus.memory_out[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!empty) state_nxt = START;
      START: if (baud_done) state_nxt = DATA;
      DATA:  if (baud_done && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
        state_nxt = PARITY;
`else
        state_nxt = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_done) state_nxt = STOP;
`endif
      STOP:  if (baud_done) state_nxt = empty ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  // tx is registered from the state's line level, so it trails the FSM by one clock.
  always_comb begin
    tx_nxt = 1'b1;
    pop    = 1'b0;
    case (state)
      IDLE:   pop    = !empty;
      START:  tx_nxt = 1'b0;
      DATA:   tx_nxt = shreg[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_nxt = par;
`endif
      STOP:   pop    = baud_done && !empty;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx       <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      tx <= tx_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (wr_stat_hit)                      overflow <= 1'b0;
      else if (wr_data_hit && full && !pop) overflow <= 1'b1;

      if (pop) begin
        shreg  <= mem[rd_ptr[LW-1:0]];
        rd_ptr <= rd_ptr + PTR_ONE;
`ifdef UART_TX_PARITY_EN
        par    <= ^mem[rd_ptr[LW-1:0]];
`endif
      end else if (state == DATA && baud_done) begin
        shreg <= shreg >> 1;
      end

      if (state == IDLE || baud_done) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + 16'd1;

      if (state != DATA)  bit_cnt <= '0;
      else if (baud_done) bit_cnt <= bit_cnt + 3'd1;
    end
  end
endmodule

// File: doc/uart_tx_mmio.md
UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 SHALL take parameter BASE, default 30'h3FFFFFC0; word address of TXDATA, with STATUS at BASE+1 (byte addresses 0xFFFFFF00 and 0xFFFFFF04).
REQ-002 SHALL take parameter CLKS_PER_BIT, default 4; clocks per serial bit, legal range 2..65535.
REQ-003 SHALL take parameter FIFO_DEPTH, default 4; TX FIFO entries, power of two in the range 2..16.
REQ-004 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-low reset.
REQ-006 Port: address  input  30  word address [31:2] driven by the cpu.
REQ-007 Port: memory_out  input  32  cpu write data; only bits [7:0] are used.
REQ-008 Port: write_enable  input  1  cpu write strobe.
REQ-009 Port: memory_in  output  32  read data returned to the cpu.
REQ-010 Port: read_capable  output  1  high when address is BASE or BASE+1.
REQ-011 Port: write_capable  output  1  high when address == BASE.
REQ-012 Port: tx  output  1  serial line, idle high.

Function
REQ-013 read_capable, write_capable and memory_in SHALL be combinational decodes of address; memory_in = 0 when read_capable is low.
REQ-014 Read of BASE SHALL return 32'd0; read of BASE+1 SHALL return STATUS = {26'd0, overflow, busy, full, empty, level[1:0]} when FIFO_DEPTH=4; level field width = log2(FIFO_DEPTH).
REQ-015 When address==BASE, write_enable=1 and the FIFO is not full, the design SHALL push memory_out[7:0] into the FIFO at the rising edge.
REQ-016 If full, a push SHALL be dropped and the sticky overflow flag set; it is cleared only by reset or by any write to BASE+1.
REQ-017 When push and pop coincide on a full FIFO, the push SHALL be accepted and the level SHALL be unchanged.
REQ-018 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be unambiguous via an extra pointer bit or a separate count.
REQ-019 TX FSM states SHALL be IDLE, START, DATA, PARITY (when REQ-027 applies), and STOP.
REQ-020 From IDLE with the FIFO non-empty, the FSM SHALL pop one byte into the shift register and enter START; tx falls on the edge after the pop.
REQ-021 START, each DATA bit, PARITY and STOP SHALL each hold tx for exactly CLKS_PER_BIT clocks; DATA is sent LSB first, with 8 bits counted 0..7.
REQ-022 After STOP, the FSM SHALL pop the next byte directly if the FIFO is non-empty, giving back-to-back frames with no idle gap; otherwise it SHALL return to IDLE.
REQ-023 busy SHALL be high whenever the FSM is not in IDLE.
REQ-024 A byte pushed into an empty FIFO while in IDLE at edge N SHALL be popped at edge N+1, with tx low from edge N+2.

Reset
REQ-025 While rst=0 the design SHALL asynchronously force tx=1, the FSM to IDLE, FIFO pointers and level to 0, overflow=0, and the baud and bit counters to 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately, with tx high and no residual bytes; after release, transmission starts only on a new push.

Configuration
REQ-027 With macro UART_TX_PARITY_EN defined, the design SHALL insert the PARITY state after DATA, transmitting the even parity bit (XOR of the 8 data bits) for CLKS_PER_BIT clocks; a frame is then 11 bits.
REQ-028 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent and a frame SHALL be 10 bits (start, 8 data, stop).

Verification
REQ-029 Reset then write 0x55 to byte address 0xFFFFFF00 -> tx low 2 edges later; serial bits 1,0,1,0,1,0,1,0 each 4 clocks; stop high; frame 40 clocks (44 with parity, parity bit 0).
REQ-030 Five back-to-back writes 0x01..0x05 with tx idle -> first popped, next four fill FIFO; no overflow; five contiguous frames with no idle gap; STATUS empty=1, busy=0 afterwards.
REQ-031 Six writes in consecutive cycles while a frame is busy and FIFO empty -> fifth and sixth rejected only when full; overflow=1; write to 0xFFFFFF04 clears it.
REQ-032 Read 0xFFFFFF04 at reset -> memory_in=32'h4 (empty=1); read 0xFFFFFF08 -> read_capable=0, memory_in=0; write_capable=0 at 0xFFFFFF04.
REQ-033 Assert rst low mid-DATA of 0xA3 with 2 bytes queued -> tx=1 immediately; STATUS=32'h4 after release; no further frames.
REQ-034 Push while FIFO full on the same cycle as the FSM pop -> byte accepted, level stays FIFO_DEPTH, and all bytes are transmitted in order.
